// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing / test-pattern generator:
// pattern mode encoding, colour-bar table and default 640x480@60 timing.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLACK = 2'd2,
    MODE_FLASH = 2'd3
  } mode_e;

  // Default 640x480@60 timing set.
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK_PORCH  = 33;

  // Per-bar channel enables {r, g, b}, left to right:
  // red, green, blue, white, black, cyan, yellow, magenta.
  localparam logic [2:0] BAR_COLOURS [8] = '{
    3'b100, 3'b010, 3'b001, 3'b111, 3'b000, 3'b011, 3'b110, 3'b101
  };

  // Expand a bar index into a 24-bit {R,G,B} pixel at the given intensity.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx, input logic [7:0] lvl);
    logic [2:0] en;
    en = BAR_COLOURS[idx];
    return {en[2] ? lvl : 8'd0, en[1] ? lvl : 8'd0, en[0] ? lvl : 8'd0};
  endfunction

endpackage

// File: rtl/video_timing_gen_delayline.sv
// Fixed-length register delay line. CYCLES=0 is a plain wire.
// Every stage clears to RESET_VAL so the outputs show an idle word
// immediately after reset.
module video_timing_gen_delayline #(
  parameter int               CYCLES    = 2,
  parameter int               WIDTH     = 28,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (CYCLES == 0) begin : g_bypass
      // clock and reset have no load when the line is bypassed.
      logic unused_bypass;
      assign unused_bypass = ^{clock, reset};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [CYCLES];

      // Shift the word one stage per clock.
      always_ff @(posedge clock) begin
        if (reset) begin
          // NOTE: this array is a short shift register, not a RAM, so every
          // stage is reset; downstream must never see stale sync or video.
          for (int i = 0; i < CYCLES; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < CYCLES; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[CYCLES-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing and test-pattern generator.
// Optional macro VIDEO_TIMING_FRAME_CNT_EN adds a 16-bit frame_count output
// that counts output frame_start pulses.
// Line/frame order: sync, back porch, active, front porch.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE      = DEF_H_ACTIVE,
  parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int   H_SYNC        = DEF_H_SYNC,
  parameter int   H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int   V_ACTIVE      = DEF_V_ACTIVE,
  parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int   V_SYNC        = DEF_V_SYNC,
  parameter int   V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter logic H_SYNC_POL    = 1'b0,
  parameter logic V_SYNC_POL    = 1'b0,
  parameter int   PIPE_DELAY    = 2,
  parameter int   FLASH_FRAMES  = 1,
  parameter int   CNT_W         = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [7:0]  level,
  input  logic        flash_req,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
  localparam int V_TOTAL = V_SYNC + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int WORD_W  = 28;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_B   = CNT_W'(H_SYNC + H_BACK_PORCH);
  localparam logic [CNT_W-1:0] H_ACT_E   = CNT_W'(H_SYNC + H_BACK_PORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_B   = CNT_W'(V_SYNC + V_BACK_PORCH);
  localparam logic [CNT_W-1:0] V_ACT_E   = CNT_W'(V_SYNC + V_BACK_PORCH + V_ACTIVE);
  localparam logic [7:0]       FLASH_LD  = 8'(FLASH_FRAMES);

  // Idle word {de, hsync, vsync, frame_start, rgb}: syncs inactive, no video.
  localparam logic [WORD_W-1:0] IDLE_WORD = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL, 1'b0, 24'd0};

  logic [CNT_W-1:0]  x, y, xa;
  logic              x_last, y_last, at_frame_start;
  mode_e             mode_q;
  logic [7:0]        level_q;
  logic              armed, flash_arm;
  logic [7:0]        flash_cnt;
  logic [2:0]        bar_idx;
  logic              pix_de, pix_hs, pix_vs;
  logic [23:0]       pix_rgb;
  logic [WORD_W-1:0] gen_q, dly_out;

  assign x_last         = (x == H_LAST);
  assign y_last         = (y == V_LAST);
  assign at_frame_start = (x == '0) && (y == '0);
  assign flash_arm      = flash_req && (mode_e'(mode) == MODE_FLASH);

  // Raster counters: x wraps at the line end and advances y.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (x_last) begin
      x <= '0;
      y <= y_last ? '0 : y + CNT_ONE;
    end else begin
      x <= x + CNT_ONE;
    end
  end

  // Pattern settings change only at frame start so frames are never torn.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q  <= MODE_BARS;
      level_q <= 8'd0;
    end else if (at_frame_start) begin
      mode_q  <= mode_e'(mode);
      level_q <= level;
    end
  end

  // Flash arming and frame countdown; a re-arm waits for the current flash.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed     <= 1'b0;
      flash_cnt <= 8'd0;
    end else begin
      if (at_frame_start) begin
        if (flash_cnt > 8'd1) flash_cnt <= flash_cnt - 8'd1;
        else if (armed)       flash_cnt <= FLASH_LD;
        else                  flash_cnt <= 8'd0;
      end
      if (flash_arm)
        armed <= 1'b1;
      else if (at_frame_start && (flash_cnt <= 8'd1))
        armed <= 1'b0;
    end
  end

  // Sync, data-enable and bar index decode from the counters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    pix_hs  = (x < H_SYNC_E) ? H_SYNC_POL : ~H_SYNC_POL;
    pix_vs  = (y < V_SYNC_E) ? V_SYNC_POL : ~V_SYNC_POL;
    pix_de  = (x >= H_ACT_B) && (x < H_ACT_E) && (y >= V_ACT_B) && (y < V_ACT_E);
    xa      = x - H_ACT_B;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xa >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Pixel colour for the latched mode; blanked outside the active area.
  always_comb begin
    pix_rgb = 24'd0;
    case (mode_q)
      MODE_BARS:  pix_rgb = bar_rgb(bar_idx, level_q);
      MODE_SOLID: pix_rgb = {3{level_q}};
      MODE_FLASH: pix_rgb = (flash_cnt != 8'd0) ? {3{level_q}} : 24'd0;
      default:    pix_rgb = 24'd0;
    endcase
    if (!pix_de) pix_rgb = 24'd0;
  end

  // Generation stage: one register holding the complete output word.
  always_ff @(posedge clock) begin
    if (reset) gen_q <= IDLE_WORD;
    else       gen_q <= {pix_de, pix_hs, pix_vs, at_frame_start, pix_rgb};
  end

  video_timing_gen_delayline #(
    .CYCLES   (PIPE_DELAY),
    .WIDTH    (WORD_W),
    .RESET_VAL(IDLE_WORD)
  ) u_delay (
    .clock(clock),
    .reset(reset),
    .din  (gen_q),
    .dout (dly_out)
  );

  assign {de, hsync, vsync, frame_start, red, green, blue} = dly_out;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q;

  // Count delayed frame_start pulses so the count lines up with the video.
  always_ff @(posedge clock) begin
    if (reset)            frame_count_q <= 16'd0;
    else if (frame_start) frame_count_q <= frame_count_q + 16'd1;
  end

  assign frame_count = frame_count_q;
`endif

endmodule
